// File: rtl/aes256_ct_collector.sv
// aes256_ct_collector
//   Fetches the 16 ciphertext bytes of each block announced by enc_done over a
//   one-byte-at-a-time req/ready handshake, reassembles them MSB-first into a
//   128-bit block and queues the block in a first-word-fall-through FIFO that
//   feeds a valid/ready output stream.
// Ports
//   clk, rst            clock (rising edge), asynchronous active-low reset
//   enc_done            pulse: a ciphertext block is available upstream
//   next_val_req        pulse: request the next ciphertext byte
//   next_val_ready      pulse: ct_byte is valid this cycle
//   ct_byte             ciphertext byte
//   m_valid, m_ready    output stream handshake
//   m_data              head block; first fetched byte in [127:120], 0 when empty
//   fifo_count          blocks currently held
//   busy                fetch FSM not idle
//   overrun_err         sticky: an enc_done arrived while one was already pending
//   timeout_err         sticky: a byte handshake timed out
//   err_clr             synchronous clear of both sticky errors (wins over a set)
module aes256_ct_collector #(
   parameter int unsigned FIFO_DEPTH  = 4,
   parameter int unsigned TIMEOUT_CYC = 255
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          enc_done,
   output logic                          next_val_req,
   input  logic                          next_val_ready,
   input  logic [7:0]                    ct_byte,
   output logic                          m_valid,
   input  logic                          m_ready,
   output logic [127:0]                  m_data,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
   output logic                          busy,
   output logic                          overrun_err,
   output logic                          timeout_err,
   input  logic                          err_clr
);

   localparam int unsigned PtrW       = $clog2(FIFO_DEPTH);
   localparam logic [PtrW:0] DepthVal = (PtrW + 1)'(FIFO_DEPTH);
   localparam logic [15:0] TimeoutVal = 16'(TIMEOUT_CYC);

   typedef enum logic [1:0] {StIdle, StReq, StWait, StPush} state_e;

   state_e          state_q;
   logic [3:0]      byte_cnt_q;
   logic [15:0]     timer_q;
   logic [127:0]    shreg_q;
   logic            req_q;
   logic            pending_q;
   logic            overrun_q;
   logic            timeout_q;

   logic [PtrW-1:0] wr_ptr_q;
   logic [PtrW-1:0] rd_ptr_q;
   logic [PtrW:0]   count_q;
   logic [127:0]    mem_q [FIFO_DEPTH];

   logic            fifo_full;
   logic            leave_idle;
   logic [15:0]     timer_inc;
   logic            timeout_hit;
   logic            push;
   logic            pop;
   logic            overrun_set;

   assign fifo_full   = (count_q == DepthVal);
   // A pending block is only fetched when its FIFO slot is guaranteed.
   assign leave_idle  = (state_q == StIdle) && pending_q && !fifo_full;
   assign timer_inc   = timer_q + 16'd1;
   // timer_inc counts this WAIT cycle, so the error fires on the TIMEOUT_CYC-th idle cycle.
   assign timeout_hit = (state_q == StWait) && !next_val_ready && (timer_inc >= TimeoutVal);
   assign push        = (state_q == StPush);
   assign pop         = m_valid && m_ready;
   assign overrun_set = enc_done && pending_q && !leave_idle;

   // Fetch FSM with its datapath; next_val_req is registered and high only in StReq.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= StIdle;
         byte_cnt_q <= 4'd0;
         timer_q    <= 16'd0;
         shreg_q    <= '0;
         req_q      <= 1'b0;
      end else begin
         req_q <= 1'b0;
         unique case (state_q)
            StIdle: begin
               if (leave_idle) begin
                  state_q    <= StReq;
                  byte_cnt_q <= 4'd0;
                  req_q      <= 1'b1;
               end
            end
            StReq: begin
               timer_q <= 16'd0;
               state_q <= StWait;
            end
            StWait: begin
               if (next_val_ready) begin
                  shreg_q    <= {shreg_q[119:0], ct_byte};
                  byte_cnt_q <= byte_cnt_q + 4'd1;
                  if (byte_cnt_q == 4'd15) begin
                     state_q <= StPush;
                  end else begin
                     state_q <= StReq;
                     req_q   <= 1'b1;
                  end
               end else if (timeout_hit) begin
                  timer_q <= TimeoutVal;
                  shreg_q <= '0;
                  state_q <= StIdle;
               end else begin
                  timer_q <= timer_inc;
               end
            end
            StPush: begin
               state_q <= StIdle;
            end
            default: begin
               state_q <= StIdle;
            end
         endcase
      end
   end

   // Pending flag and sticky errors; a second enc_done only raises overrun, one fetch follows.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pending_q <= 1'b0;
         overrun_q <= 1'b0;
         timeout_q <= 1'b0;
      end else begin
         pending_q <= (pending_q && !leave_idle) || enc_done;
         if (err_clr) begin
            overrun_q <= 1'b0;
            timeout_q <= 1'b0;
         end else begin
            if (overrun_set) overrun_q <= 1'b1;
            if (timeout_hit) timeout_q <= 1'b1;
         end
      end
   end

   // Block FIFO control; pointers wrap naturally because the depth is a power of two.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
         if (pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
         unique case ({push, pop})
            2'b10:   count_q <= count_q + (PtrW + 1)'(1);
            2'b01:   count_q <= count_q - (PtrW + 1)'(1);
            default: count_q <= count_q;
         endcase
      end
   end

   // Storage needs no reset: the output is masked while the FIFO is empty.
   always_ff @(posedge clk) begin
      if (push) mem_q[wr_ptr_q] <= shreg_q;
   end

   assign m_valid      = (count_q != '0);
   assign m_data       = m_valid ? mem_q[rd_ptr_q] : '0;
   assign fifo_count   = count_q;
   assign next_val_req = req_q;
   assign busy         = (state_q != StIdle);
   assign overrun_err  = overrun_q;
   assign timeout_err  = timeout_q;

endmodule

// File: tb/tb_aes256_ct_collector.sv
// Directed bench for aes256_ct_collector: a table of blocks with literal expected
// data, then hand-written sequences for FIFO back-pressure, overrun, timeout,
// reset mid-block and simultaneous push/pop.
module tb_aes256_ct_collector;

   logic         clk = 1'b0;
   logic         rst;
   logic         enc_done;
   logic         next_val_req;
   logic         next_val_ready;
   logic [7:0]   ct_byte;
   logic         m_valid;
   logic         m_ready;
   logic [127:0] m_data;
   logic [2:0]   fifo_count;
   logic         busy;
   logic         overrun_err;
   logic         timeout_err;
   logic         err_clr;

   int nvec  = 0;
   int nfail = 0;
   int req_cnt = 0;
   int cyc = 0;

   always #5 clk = ~clk;

   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (next_val_req) req_cnt <= req_cnt + 1;
   end

   aes256_ct_collector #(
      .FIFO_DEPTH (4),
      .TIMEOUT_CYC(8)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .enc_done      (enc_done),
      .next_val_req  (next_val_req),
      .next_val_ready(next_val_ready),
      .ct_byte       (ct_byte),
      .m_valid       (m_valid),
      .m_ready       (m_ready),
      .m_data        (m_data),
      .fifo_count    (fifo_count),
      .busy          (busy),
      .overrun_err   (overrun_err),
      .timeout_err   (timeout_err),
      .err_clr       (err_clr)
   );

   typedef struct {
      logic [7:0]   base;
      logic [127:0] exp;
   } vec_t;

   vec_t vecs [4];

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      nvec++;
      if (act !== exp) begin
         nfail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic logic [127:0] exp_block(input logic [7:0] base);
      logic [127:0] r = '0;
      for (int i = 0; i < 16; i++) r = {r[119:0], 8'(base + 8'(i))};
      return r;
   endfunction

   task automatic pulse_enc();
      enc_done = 1'b1;
      tick();
      enc_done = 1'b0;
   endtask

   // Loading-stage model: answers each req in the following cycle with base+i.
   // Stops without answering at byte stall_at. Returns at the negedge of the PUSH
   // cycle (or of the unanswered REQ cycle).
   task automatic serve(input logic [7:0] base, input int stall_at, output int t0);
      t0 = 0;
      for (int i = 0; i < 16; i++) begin
         int w = 0;
         while (!next_val_req && w < 100) begin
            tick();
            w++;
         end
         if (!next_val_req) begin
            check("req_wait", 128'(next_val_req), 128'd1);
            return;
         end
         if (i == 0) t0 = cyc;
         if (i == stall_at) return;
         tick();
         next_val_ready = 1'b1;
         ct_byte        = 8'(base + 8'(i));
         tick();
         next_val_ready = 1'b0;
      end
   endtask

   task automatic pop_check(input string name, input logic [7:0] base);
      check({name, "_valid"}, 128'(m_valid), 128'd1);
      check({name, "_data"}, m_data, exp_block(base));
      m_ready = 1'b1;
      tick();
      m_ready = 1'b0;
   endtask

   initial begin
      int t0;
      int r0;

      vecs[0] = '{8'h00, 128'h000102030405060708090A0B0C0D0E0F};
      vecs[1] = '{8'h10, 128'h101112131415161718191A1B1C1D1E1F};
      vecs[2] = '{8'hA5, 128'hA5A6A7A8A9AAABACADAEAFB0B1B2B3B4};
      vecs[3] = '{8'hF8, 128'hF8F9FAFBFCFDFEFF0001020304050607};

      rst = 1'b0;
      enc_done = 1'b0;
      next_val_ready = 1'b0;
      ct_byte = 8'h00;
      m_ready = 1'b0;
      err_clr = 1'b0;
      repeat (2) tick();
      check("rst_req", 128'(next_val_req), 128'd0);
      check("rst_valid", 128'(m_valid), 128'd0);
      check("rst_data", m_data, 128'd0);
      check("rst_count", 128'(fifo_count), 128'd0);
      check("rst_busy", 128'(busy), 128'd0);
      check("rst_errs", 128'({overrun_err, timeout_err}), 128'd0);
      rst = 1'b1;
      tick();

      // Table: single blocks through an always-ready sink.
      m_ready = 1'b1;
      for (int v = 0; v < 4; v++) begin
         r0 = req_cnt;
         pulse_enc();
         serve(vecs[v].base, -1, t0);
         tick();
         check("vec_valid", 128'(m_valid), 128'd1);
         check("vec_data", m_data, vecs[v].exp);
         check("vec_latency", 128'(cyc - t0), 128'd33);
         tick();
         check("vec_valid_1cyc", 128'(m_valid), 128'd0);
         check("vec_req_pulses", 128'(req_cnt - r0), 128'd16);
      end
      m_ready = 1'b0;

      // Fill the FIFO, then back-pressure and overrun.
      for (int k = 0; k < 4; k++) begin
         pulse_enc();
         serve(8'(8'h40 + 8'(16 * k)), -1, t0);
         tick();
         check("fill_count", 128'(fifo_count), 128'(k + 1));
      end
      pulse_enc();
      r0 = req_cnt;
      repeat (5) tick();
      check("ovr_before", 128'(overrun_err), 128'd0);
      pulse_enc();
      tick();
      check("ovr_set", 128'(overrun_err), 128'd1);
      repeat (30) tick();
      check("full_no_req", 128'(req_cnt - r0), 128'd0);
      check("full_idle", 128'(busy), 128'd0);
      check("full_count", 128'(fifo_count), 128'd4);
      pop_check("full_pop0", 8'h40);
      serve(8'h80, -1, t0);
      tick();
      check("refill_count", 128'(fifo_count), 128'd4);
      r0 = req_cnt;
      repeat (40) tick();
      check("ovr_one_fetch", 128'(req_cnt - r0), 128'd0);
      err_clr = 1'b1;
      tick();
      err_clr = 1'b0;
      check("ovr_clr", 128'(overrun_err), 128'd0);
      pop_check("order1", 8'h50);
      pop_check("order2", 8'h60);
      pop_check("order3", 8'h70);
      pop_check("order4", 8'h80);
      check("drain_count", 128'(fifo_count), 128'd0);

      // Simultaneous push and pop at count = depth-1.
      for (int k = 0; k < 3; k++) begin
         pulse_enc();
         serve(8'(8'h90 + 8'(16 * k)), -1, t0);
         tick();
      end
      pulse_enc();
      serve(8'hC0, -1, t0);
      check("pp_count_pre", 128'(fifo_count), 128'd3);
      check("pp_head", m_data, exp_block(8'h90));
      m_ready = 1'b1;
      tick();
      m_ready = 1'b0;
      check("pp_count_post", 128'(fifo_count), 128'd3);
      pop_check("pp_order1", 8'hA0);
      pop_check("pp_order2", 8'hB0);
      pop_check("pp_order3", 8'hC0);

      // Timeout on byte 5.
      pulse_enc();
      serve(8'hD0, 5, t0);
      repeat (8) tick();
      check("to_not_yet", 128'(timeout_err), 128'd0);
      check("to_busy", 128'(busy), 128'd1);
      tick();
      check("to_set", 128'(timeout_err), 128'd1);
      check("to_idle", 128'(busy), 128'd0);
      check("to_count", 128'(fifo_count), 128'd0);
      pulse_enc();
      serve(8'hE0, -1, t0);
      tick();
      pop_check("to_clean", 8'hE0);
      check("to_sticky", 128'(timeout_err), 128'd1);

      // Asynchronous reset in the middle of byte 9 with a block queued.
      pulse_enc();
      serve(8'h33, -1, t0);
      tick();
      pulse_enc();
      serve(8'h01, 9, t0);
      rst = 1'b0;
      #1;
      check("arst_req", 128'(next_val_req), 128'd0);
      check("arst_valid", 128'(m_valid), 128'd0);
      check("arst_data", m_data, 128'd0);
      check("arst_count", 128'(fifo_count), 128'd0);
      check("arst_busy", 128'(busy), 128'd0);
      check("arst_errs", 128'({overrun_err, timeout_err}), 128'd0);
      tick();
      tick();
      rst = 1'b1;
      tick();
      pulse_enc();
      serve(8'h20, -1, t0);
      tick();
      pop_check("post_rst", 8'h20);
      check("post_rst_count", 128'(fifo_count), 128'd0);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
      $finish;
   end

endmodule
